// File: rtl/gate_sweep_ctrl_if.sv
// Result channel of gate_sweep_ctrl: one record per swept gate type.
// Handshake: a record moves when result_valid and result_ready are both high
// at a rising clk edge; while result_valid is high and result_ready is low the
// master holds result_type, result_tt and result_pass unchanged, and
// result_valid never drops without a completed transfer (except on reset).
interface gate_sweep_ctrl_if;
  logic       result_valid;
  logic       result_ready;
  logic [2:0] result_type;
  logic [3:0] result_tt;
  logic       result_pass;

  modport master (
    output result_valid,
    output result_type,
    output result_tt,
    output result_pass,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_type,
    input  result_tt,
    input  result_pass,
    output result_ready
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: built-in self-test sequencer for the combinational
// gate-select unit. For each gate type it drives the four {A,B} vectors,
// holds each one SETTLE_CYCLES cycles, captures gate_o into a 4-bit truth
// table (bit index = {A,B}), and emits type/table/pass on the result channel.
// Optional build macro GATE_SWEEP_STOP_ON_FAIL_EN: when defined, the sweep
// ends right after the first failing result is accepted.
// dbg_state exposes the FSM state (0 IDLE, 1 SETTLE, 2 EMIT, 3 DONE).
module gate_sweep_ctrl #(
  parameter int NUM_TYPES     = 7,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              gate_a,
  output logic              gate_b,
  output logic [2:0]        gate_type,
  input  logic              gate_o,
  gate_sweep_ctrl_if.master res,
  output logic [3:0]        fail_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LP_SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LP_LAST_TYPE     = 3'(NUM_TYPES - 1);

  // Expected truth table, bit3..bit0 = {A,B} = 11,10,01,00.
  function automatic logic [3:0] exp_tt(input logic [2:0] t);
    case (t)
      3'd0:    exp_tt = 4'b1000; // AND
      3'd1:    exp_tt = 4'b1110; // OR
      3'd2:    exp_tt = 4'b0011; // NOT A
      3'd3:    exp_tt = 4'b0111; // NAND
      3'd4:    exp_tt = 4'b0001; // NOR
      3'd5:    exp_tt = 4'b0110; // XOR
      3'd6:    exp_tt = 4'b1001; // XNOR
      default: exp_tt = 4'b0000; // code 7: gate unit outputs constant 0
    endcase
  endfunction

  state_t     r_state, w_state_nxt;
  logic [2:0] r_type, w_type_nxt;
  logic [1:0] r_combo, w_combo_nxt;
  logic [3:0] r_settle, w_settle_nxt;
  logic [3:0] r_tt, w_tt_nxt;
  logic [3:0] r_fail, w_fail_nxt;
  logic       r_gate_a, w_gate_a_nxt;
  logic       r_gate_b, w_gate_b_nxt;
  logic [2:0] r_gate_type, w_gate_type_nxt;

  logic       w_emit;
  logic       w_pass;
  logic       w_handshake;
  logic       w_stop;

  assign w_emit      = (r_state == ST_EMIT);
  assign w_pass      = (r_tt == exp_tt(r_type));
  assign w_handshake = w_emit && res.result_ready;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign w_stop = (r_type == LP_LAST_TYPE) || !w_pass;
`else
  assign w_stop = (r_type == LP_LAST_TYPE);
`endif

  // Next-state and datapath next values; everything defaults to hold.
  always_comb begin
    w_state_nxt     = r_state;
    w_type_nxt      = r_type;
    w_combo_nxt     = r_combo;
    w_settle_nxt    = r_settle;
    w_tt_nxt        = r_tt;
    w_fail_nxt      = r_fail;
    w_gate_a_nxt    = r_gate_a;
    w_gate_b_nxt    = r_gate_b;
    w_gate_type_nxt = r_gate_type;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt     = ST_SETTLE;
          w_type_nxt      = 3'd0;
          w_combo_nxt     = 2'd0;
          w_tt_nxt        = 4'd0;
          w_settle_nxt    = LP_SETTLE_RELOAD;
          w_fail_nxt      = 4'd0;
          w_gate_a_nxt    = 1'b0;
          w_gate_b_nxt    = 1'b0;
          w_gate_type_nxt = 3'd0;
        end
      end
      ST_SETTLE: begin
        if (r_settle != 4'd0) begin
          w_settle_nxt = r_settle - 4'd1;
        end else begin
          w_tt_nxt[r_combo] = gate_o;
          if (r_combo == 2'd3) begin
            // Vector {1,1} stays on the gate pins while the result waits.
            w_state_nxt = ST_EMIT;
          end else begin
            w_combo_nxt  = r_combo + 2'd1;
            w_settle_nxt = LP_SETTLE_RELOAD;
            w_gate_a_nxt = w_combo_nxt[1];
            w_gate_b_nxt = w_combo_nxt[0];
          end
        end
      end
      ST_EMIT: begin
        if (w_handshake) begin
          if (!w_pass) begin
            w_fail_nxt = r_fail + 4'd1;
          end
          if (w_stop) begin
            w_state_nxt     = ST_DONE;
            w_gate_a_nxt    = 1'b0;
            w_gate_b_nxt    = 1'b0;
            w_gate_type_nxt = 3'd0;
          end else begin
            w_state_nxt     = ST_SETTLE;
            w_type_nxt      = r_type + 3'd1;
            w_combo_nxt     = 2'd0;
            w_tt_nxt        = 4'd0;
            w_settle_nxt    = LP_SETTLE_RELOAD;
            w_gate_a_nxt    = 1'b0;
            w_gate_b_nxt    = 1'b0;
            w_gate_type_nxt = r_type + 3'd1;
          end
        end
      end
      default: begin
        // DONE lasts one cycle; start is not looked at here.
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_type      <= 3'd0;
      r_combo     <= 2'd0;
      r_settle    <= 4'd0;
      r_tt        <= 4'd0;
      r_fail      <= 4'd0;
      r_gate_a    <= 1'b0;
      r_gate_b    <= 1'b0;
      r_gate_type <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_type      <= w_type_nxt;
      r_combo     <= w_combo_nxt;
      r_settle    <= w_settle_nxt;
      r_tt        <= w_tt_nxt;
      r_fail      <= w_fail_nxt;
      r_gate_a    <= w_gate_a_nxt;
      r_gate_b    <= w_gate_b_nxt;
      r_gate_type <= w_gate_type_nxt;
    end
  end

  assign busy       = (r_state == ST_SETTLE) || w_emit;
  assign done       = (r_state == ST_DONE);
  assign gate_a     = r_gate_a;
  assign gate_b     = r_gate_b;
  assign gate_type  = r_gate_type;
  assign fail_count = r_fail;
  assign dbg_state  = r_state;

  // Result fields read as zero outside EMIT so idle values carry no meaning.
  assign res.result_valid = w_emit;
  assign res.result_type  = w_emit ? r_type : 3'd0;
  assign res.result_tt    = w_emit ? r_tt : 4'd0;
  assign res.result_pass  = w_emit && w_pass;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Testbench for gate_sweep_ctrl. dut runs with default parameters against a
// behavioural gate unit (optionally stuck at 0); dut3 runs with
// SETTLE_CYCLES=3 to check vector hold time and first-result latency.
module tb_gate_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy, done, gate_a, gate_b, gate_o;
  logic [2:0] gate_type;
  logic [3:0] fail_count;
  logic [1:0] dbg_state;
  logic       force0;

  logic       start3;
  logic       busy3, done3, gate_a3, gate_b3, gate_o3;
  logic [2:0] gate_type3;
  logic [3:0] fail_count3;
  logic [1:0] dbg_state3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  gate_sweep_ctrl_if res_if ();
  gate_sweep_ctrl_if res3_if ();

  // Behavioural gate unit written from the gate list, not from the table.
  function automatic logic gate_fn(input logic [2:0] t, input logic a, input logic b);
    case (t)
      3'd0:    gate_fn = a & b;
      3'd1:    gate_fn = a | b;
      3'd2:    gate_fn = ~a;
      3'd3:    gate_fn = ~(a & b);
      3'd4:    gate_fn = ~(a | b);
      3'd5:    gate_fn = a ^ b;
      3'd6:    gate_fn = ~(a ^ b);
      default: gate_fn = 1'b0;
    endcase
  endfunction

  // Expected tables as listed for the gate unit.
  function automatic logic [3:0] tb_exp(input logic [2:0] t);
    case (t)
      3'd0:    tb_exp = 4'b1000;
      3'd1:    tb_exp = 4'b1110;
      3'd2:    tb_exp = 4'b0011;
      3'd3:    tb_exp = 4'b0111;
      3'd4:    tb_exp = 4'b0001;
      3'd5:    tb_exp = 4'b0110;
      3'd6:    tb_exp = 4'b1001;
      default: tb_exp = 4'b0000;
    endcase
  endfunction

  assign gate_o  = force0 ? 1'b0 : gate_fn(gate_type, gate_a, gate_b);
  assign gate_o3 = gate_fn(gate_type3, gate_a3, gate_b3);
  assign res3_if.result_ready = 1'b1;

  gate_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .gate_a     (gate_a),
    .gate_b     (gate_b),
    .gate_type  (gate_type),
    .gate_o     (gate_o),
    .res        (res_if),
    .fail_count (fail_count),
    .dbg_state  (dbg_state)
  );

  gate_sweep_ctrl #(.NUM_TYPES(7), .SETTLE_CYCLES(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .busy       (busy3),
    .done       (done3),
    .gate_a     (gate_a3),
    .gate_b     (gate_b3),
    .gate_type  (gate_type3),
    .gate_o     (gate_o3),
    .res        (res3_if),
    .fail_count (fail_count3),
    .dbg_state  (dbg_state3)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted result must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && res_if.result_valid && res_if.result_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", {24'd0, res_if.result_type, res_if.result_tt, res_if.result_pass}, 32'hFFFF_FFFF);
      end else begin
        check("sb_result", {24'd0, res_if.result_type, res_if.result_tt, res_if.result_pass},
              {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_sweep(input bit stuck0, input int n_types);
    for (int t = 0; t < n_types; t++) begin
      logic [3:0] tt;
      tt = stuck0 ? 4'b0000 : tb_exp(3'(t));
      exp_q.push_back({3'(t), tt, (tt == tb_exp(3'(t)))});
    end
  endtask

  // start is sampled at the second edge; returns 1 ns after that edge.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_start3();
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
  endtask

  // Counts edges until done is seen just after an edge.
  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_gate_type(input string tag, input logic [2:0] t, input int budget);
    int n;
    n = 0;
    while (n < budget && gate_type != t) begin
      @(posedge clk); #1;
      n++;
    end
    if (gate_type != t) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_gate"}, {gate_a, gate_b, gate_type}, 0);
    check({tag, "_valid"}, res_if.result_valid, 0);
    check({tag, "_fields"}, {res_if.result_type, res_if.result_tt, res_if.result_pass}, 0);
    check({tag, "_fail_count"}, fail_count, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    force0 = 1'b0;
    res_if.result_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Full sweep, working gate unit, ready high.
    // Start edge is cycle 0; DONE occupies cycle 36 (7*(4+1) + 1).
    push_sweep(1'b0, 7);
    pulse_start();
    check("a_busy_after_start", busy, 1);
    wait_done("a_done", 100, n);
    check("a_done_cycle", n, 35);
    check("a_fail_count", fail_count, 0);
    check("a_busy_in_done", busy, 0);
    @(posedge clk); #1;
    check("a_done_one_cycle", done, 0);
    check("a_back_idle", dbg_state, 0);
    check("a_queue_drained", exp_q.size(), 0);

    // Gate unit stuck at 0
    force0 = 1'b1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    push_sweep(1'b1, 1);
    pulse_start();
    wait_done("b_done", 100, n);
    check("b_done_cycle", n, 5);
    check("b_fail_count", fail_count, 1);
`else
    push_sweep(1'b1, 7);
    pulse_start();
    wait_done("b_done", 100, n);
    check("b_done_cycle", n, 35);
    check("b_fail_count", fail_count, 7);
`endif
    check("b_queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    check("b_fail_count_holds", fail_count, fail_count == 4'd0 ? 4'd15 : fail_count);
    force0 = 1'b0;

    // Back-pressure during the type-2 result
    push_sweep(1'b0, 7);
    pulse_start();
    check("c_fail_count_cleared", fail_count, 0);
    n = 0;
    while (n < 40 && !(res_if.result_valid && res_if.result_type == 3'd2)) begin
      @(posedge clk); #1;
      n++;
    end
    check("c_reach_type2_cycle", n, 14);
    res_if.result_ready = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("c_stall_valid", res_if.result_valid, 1);
      check("c_stall_fields", {res_if.result_type, res_if.result_tt, res_if.result_pass}, {3'd2, 4'b0011, 1'b1});
      check("c_stall_gate", {gate_a, gate_b, gate_type}, {1'b1, 1'b1, 3'd2});
    end
    res_if.result_ready = 1'b1;
    wait_done("c_done", 100, n);
    check("c_done_cycle", n, 21);
    check("c_fail_count", fail_count, 0);
    check("c_queue_drained", exp_q.size(), 0);

    // SETTLE_CYCLES=3: each vector held 3 cycles, first valid 12 cycles on
    pulse_start3();
    for (int i = 0; i < 12; i++) begin
      logic [1:0] c;
      c = 2'(i / 3);
      check("d_vector", {gate_a3, gate_b3, gate_type3}, {c[1], c[0], 3'd0});
      check("d_valid_low", res3_if.result_valid, 0);
      @(posedge clk); #1;
    end
    check("d_first_valid", res3_if.result_valid, 1);
    check("d_first_fields", {res3_if.result_type, res3_if.result_tt, res3_if.result_pass}, {3'd0, 4'b1000, 1'b1});
    n = 0;
    while (n < 200 && !done3) begin
      @(posedge clk); #1;
      n++;
    end
    check("d_done_cycle", n, 79);
    check("d_fail_count", fail_count3, 0);
    @(posedge clk); #1;
    check("d_idle", {busy3, dbg_state3}, 0);

    // Ignored start while busy, then reset during type 4
    push_sweep(1'b0, 4);
    pulse_start();
    wait_gate_type("e_type1", 3'd1, 40);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_gate_type("e_type4", 3'd4, 40);
    check("e_busy_type4", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("e_async_reset");
    start = 1'b1;
    @(posedge clk); #1;
    check("e_rst_beats_start", dbg_state, 0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("e_idle_after_reset", {busy, dbg_state}, 0);
    check("e_queue_drained", exp_q.size(), 0);
    push_sweep(1'b0, 7);
    pulse_start();
    check("e_restart_type0", {busy, gate_type}, {1'b1, 3'd0});
    wait_done("e_done", 100, n);
    check("e_done_cycle", n, 35);
    check("e_fail_count", fail_count, 0);
    check("e_queue_final", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Upstream sequencer for the combinational gate-select unit. Drives its A, B and gate-type inputs and samples its single output bit.
- Per gate type, walks all four {A,B} combinations and assembles a 4-bit truth table.
- Checks the table against the expected value and emits one result per type over a valid/ready handshake.
- Serves as the built-in self-test and characterisation stage for the gate unit.

Parameters:
- NUM_TYPES, 7, number of gate types swept, codes 0..NUM_TYPES-1; legal range 1..8.
- SETTLE_CYCLES, 1, cycles each {type,A,B} vector is held before gate_o is captured; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; ignored unless idle.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep ends.
- gate_a  output  1  drives the gate unit's A input.
- gate_b  output  1  drives the gate unit's B input.
- gate_type  output  3  drives the gate unit's type select.
- gate_o  input  1  gate unit output, combinational from gate_a/gate_b/gate_type.
- result_valid  output  1  result fields valid.
- result_ready  input  1  downstream accepts the result.
- result_type  output  3  gate code of the current result.
- result_tt  output  4  captured truth table; bit index = {A,B}.
- result_pass  output  1  result_tt equals the expected table.
- fail_count  output  4  number of failing types in the current sweep.

Behaviour:
- Reset: the interface is the decided one clock, clk, and one reset, rst, which is asynchronous and active-high. Asserting rst forces IDLE immediately, including mid-sweep. All outputs go to 0: busy, done, gate_a, gate_b, gate_type, result_valid, result_type, result_tt, result_pass, fail_count. The internal type counter, combo counter, settle counter and truth-table register also clear to 0.
- States: IDLE, SETTLE, EMIT, DONE.
- IDLE:
  - busy=0. gate_* hold 0.
  - start=1 at an edge: type=0, combo=0, tt=0, settle=SETTLE_CYCLES-1, fail_count=0, go to SETTLE.
- SETTLE:
  - busy=1. gate_type=type, gate_a=combo[1], gate_b=combo[0], all registered.
  - While settle>0, decrement settle.
  - When settle==0, capture tt[combo]<=gate_o.
  - If combo==3, go to EMIT. Otherwise combo++, reload settle, stay in SETTLE.
- EMIT:
  - result_valid=1, result_type=type, result_tt=tt.
  - result_pass=(tt==EXP(type)), computed combinationally from the registered tt.
  - Fields stay stable until the handshake, valid&ready at an edge.
  - On handshake: fail_count increments if !result_pass, and result_valid drops the next cycle.
  - If type==NUM_TYPES-1, go to DONE. Otherwise type++, combo=0, tt=0, reload settle, go to SETTLE.
- DONE: busy=0, done=1 for exactly one cycle, then IDLE. fail_count holds until the next accepted start.
- EXP table, bit3..bit0 = {A,B}=11,10,01,00:
  - 0 AND=1000
  - 1 OR=1110
  - 2 NOT A=0011
  - 3 NAND=0111
  - 4 NOR=0001
  - 5 XOR=0110
  - 6 XNOR=1001
  - 7=0000, because the gate unit outputs 0 for code 7.
- Timing: let S=SETTLE_CYCLES.
  - With start sampled at edge k, result_valid is first high in the cycle after edge k+4S.
  - Each vector is held exactly S cycles.
  - With ready tied high, each type takes 4S+1 cycles.
  - Full sweep: NUM_TYPES*(4S+1) cycles, plus 1 DONE cycle.
- Boundaries:
  - start while busy or in DONE: ignored, no restart.
  - start and rst together: rst wins.
  - result_ready low: stall indefinitely in EMIT, gate_* hold the last vector.
  - fail_count maximum is 8, so it fits in 4 bits and never wraps.
  - NUM_TYPES=1: a single EMIT, then DONE.

Optional Feature:
- Macro: GATE_SWEEP_STOP_ON_FAIL_EN.
- Defined: a handshake on a result with result_pass=0 goes straight to DONE regardless of type. fail_count is then 1, and the remaining types are not swept.
- Undefined: all NUM_TYPES types are always swept; failures only increment fail_count.

Test Plan:
- Defaults, working gate unit, ready=1, pulse start: 7 results, types 0..6, tt = 1000,1110,0011,0111,0001,0110,1001, all pass. done pulses 36 cycles after the start edge (7*(4+1) sweep cycles plus 1 DONE cycle); fail_count=0.
- gate_o forced to 0, feature undefined: every result has tt=0000 and pass=0; fail_count=7 at done.
- gate_o forced to 0, GATE_SWEEP_STOP_ON_FAIL_EN defined: one result (type 0, tt 0000, pass 0), then done; fail_count=1.
- result_ready held low 10 cycles during the type-2 EMIT: result_valid and fields stable (type 2, tt 0011), gate_a=1, gate_b=1, gate_type=2 held; sweep resumes after ready.
- SETTLE_CYCLES=3: each {A,B} vector is held exactly 3 cycles; first result_valid 12 cycles after the start edge.
- rst pulsed mid-sweep during type 4: all outputs 0 immediately and state IDLE. A start pressed during busy earlier had no effect. A new start sweeps from type 0.
